// File: rtl/pipe_stage_skid_reg.sv
// Generic valid/ready pipeline stage register with optional skid slot, synchronous
// flush and a saturating back-pressure counter.
module pipe_stage_skid_reg #(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned SKID           = 1,
   parameter int unsigned CLEAR_ON_FLUSH = 1,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   input  logic                 clr_stats,
   output logic [CNT_WIDTH-1:0] stall_cycles
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;
   logic             accept;
   logic             deliver;

   assign accept  = in_valid & in_ready;
   assign deliver = out_valid & out_ready;

   generate
      if (SKID != 0) begin : g_skid
         // Ready comes only from the skid flop, so out_ready never reaches in_ready.
         assign in_ready = !skid_valid & !flush & !reset;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               skid_valid <= 1'b0;
               skid_data  <= '0;
            end else if (flush) begin
               skid_valid <= 1'b0;
               if (CLEAR_ON_FLUSH != 0) skid_data <= '0;
            end else if (skid_valid) begin
               if (deliver) skid_valid <= 1'b0;
            end else if (accept && out_valid && !deliver) begin
               skid_valid <= 1'b1;
               skid_data  <= in_data;
            end
         end
      end else begin : g_noskid
         assign in_ready   = (!out_valid | out_ready) & !flush & !reset;
         assign skid_valid = 1'b0;
         assign skid_data  = '0;
      end
   endgenerate

   // Main register: refill from skid first, then from upstream.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         if (CLEAR_ON_FLUSH != 0) out_data <= '0;
      end else if (!out_valid) begin
         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
         end
      end else if (deliver) begin
         if (skid_valid) begin
            out_data <= skid_data;
         end else if (accept) begin
            out_data <= in_data;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

   // Saturating count of cycles where a live entry was held back by downstream.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (clr_stats) begin
         stall_cycles <= '0;
      end else if (out_valid && !out_ready && !flush && (stall_cycles != CNT_MAX)) begin
         stall_cycles <= stall_cycles + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: skid, small-counter and no-skid instances
// share one set of inputs; each scenario checks the instance it targets.
module tb_pipe_stage_skid_reg;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;
   logic        clr_stats;

   logic        ir_a, ov_a;
   logic [31:0] od_a;
   logic [15:0] sc_a;
   logic        ir_c, ov_c;
   logic [31:0] od_c;
   logic [2:0]  sc_c;
   logic        ir_z, ov_z;
   logic [31:0] od_z;
   logic [15:0] sc_z;

   int pass_cnt;
   int total_cnt;

   pipe_stage_skid_reg u_a (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir_a),
      .in_data(in_data), .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
      .clr_stats(clr_stats), .stall_cycles(sc_a));

   pipe_stage_skid_reg #(.CNT_WIDTH(3)) u_c (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir_c),
      .in_data(in_data), .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c),
      .clr_stats(clr_stats), .stall_cycles(sc_c));

   pipe_stage_skid_reg #(.SKID(0)) u_z (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir_z),
      .in_data(in_data), .out_valid(ov_z), .out_ready(out_ready), .out_data(od_z),
      .clr_stats(clr_stats), .stall_cycles(sc_z));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
      out_ready = 1'b0; clr_stats = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      total_cnt++; if (ir_a !== 1'b0) $display("FAIL rst_ready_a got %0h exp 0", ir_a); else pass_cnt++;
      total_cnt++; if (ir_z !== 1'b0) $display("FAIL rst_ready_z got %0h exp 0", ir_z); else pass_cnt++;
      total_cnt++; if (ov_a !== 1'b0) $display("FAIL rst_valid got %0h exp 0", ov_a); else pass_cnt++;
      total_cnt++; if (od_a !== 32'h0) $display("FAIL rst_data got %h exp 0", od_a); else pass_cnt++;
      total_cnt++; if (sc_a !== 16'h0) $display("FAIL rst_stall got %0d exp 0", sc_a); else pass_cnt++;
      reset = 1'b0;
      #1;
      total_cnt++; if (ir_a !== 1'b1) $display("FAIL rel_ready_a got %0h exp 1", ir_a); else pass_cnt++;
      total_cnt++; if (ir_z !== 1'b1) $display("FAIL rel_ready_z got %0h exp 1", ir_z); else pass_cnt++;
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1;
         in_data  = 32'(i);
         #1;
         total_cnt++; if (ir_a !== 1'b1) $display("FAIL stream_ready_a[%0d] got %0h exp 1", i, ir_a); else pass_cnt++;
         total_cnt++; if (ir_z !== 1'b1) $display("FAIL stream_ready_z[%0d] got %0h exp 1", i, ir_z); else pass_cnt++;
         if (i > 1) begin
            total_cnt++; if (ov_a !== 1'b1 || od_a !== 32'(i - 1))
               $display("FAIL stream_out_a[%0d] got %0h/%h exp 1/%h", i, ov_a, od_a, 32'(i - 1)); else pass_cnt++;
            total_cnt++; if (ov_z !== 1'b1 || od_z !== 32'(i - 1))
               $display("FAIL stream_out_z[%0d] got %0h/%h exp 1/%h", i, ov_z, od_z, 32'(i - 1)); else pass_cnt++;
         end
         tick();
      end
      in_valid = 1'b0;
      #1;
      total_cnt++; if (ov_a !== 1'b1 || od_a !== 32'h8) $display("FAIL stream_last_a got %0h/%h exp 1/8", ov_a, od_a); else pass_cnt++;
      total_cnt++; if (ov_z !== 1'b1 || od_z !== 32'h8) $display("FAIL stream_last_z got %0h/%h exp 1/8", ov_z, od_z); else pass_cnt++;
      tick();
      total_cnt++; if (ov_a !== 1'b0) $display("FAIL stream_drain_a got %0h exp 0", ov_a); else pass_cnt++;
      total_cnt++; if (ov_z !== 1'b0) $display("FAIL stream_drain_z got %0h exp 0", ov_z); else pass_cnt++;
      total_cnt++; if (sc_a !== 16'h0) $display("FAIL stream_stall got %0d exp 0", sc_a); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      in_valid = 1'b1; in_data = 32'h10; out_ready = 1'b1;
      tick();
      in_data = 32'h11; out_ready = 1'b0;
      #1;
      total_cnt++; if (ir_a !== 1'b1) $display("FAIL bp_absorb_ready got %0h exp 1", ir_a); else pass_cnt++;
      tick();
      in_data = 32'h12;
      #1;
      total_cnt++; if (ir_a !== 1'b0) $display("FAIL bp_ready_c2 got %0h exp 0", ir_a); else pass_cnt++;
      total_cnt++; if (od_a !== 32'h10) $display("FAIL bp_hold_c2 got %h exp 10", od_a); else pass_cnt++;
      tick();
      #1;
      total_cnt++; if (ir_a !== 1'b0) $display("FAIL bp_ready_c3 got %0h exp 0", ir_a); else pass_cnt++;
      tick();
      out_ready = 1'b1;
      #1;
      total_cnt++; if (ir_a !== 1'b0) $display("FAIL bp_ready_c4 got %0h exp 0", ir_a); else pass_cnt++;
      total_cnt++; if (ov_a !== 1'b1 || od_a !== 32'h10) $display("FAIL bp_out_10 got %0h/%h exp 1/10", ov_a, od_a); else pass_cnt++;
      total_cnt++; if (sc_a !== 16'd3) $display("FAIL bp_stall got %0d exp 3", sc_a); else pass_cnt++;
      tick();
      #1;
      total_cnt++; if (ir_a !== 1'b1) $display("FAIL bp_ready_release got %0h exp 1", ir_a); else pass_cnt++;
      total_cnt++; if (ov_a !== 1'b1 || od_a !== 32'h11) $display("FAIL bp_out_11 got %0h/%h exp 1/11", ov_a, od_a); else pass_cnt++;
      tick();
      in_valid = 1'b0;
      #1;
      total_cnt++; if (ov_a !== 1'b1 || od_a !== 32'h12) $display("FAIL bp_out_12 got %0h/%h exp 1/12", ov_a, od_a); else pass_cnt++;
      tick();
      total_cnt++; if (ov_a !== 1'b0) $display("FAIL bp_drain got %0h exp 0", ov_a); else pass_cnt++;
      total_cnt++; if (sc_a !== 16'd3) $display("FAIL bp_stall_final got %0d exp 3", sc_a); else pass_cnt++;
   endtask

   task automatic test_reset_midstream();
      in_valid = 1'b1; in_data = 32'hA5A5_0001; out_ready = 1'b0;
      tick();
      in_data = 32'hA5A5_0002;
      #1;
      total_cnt++; if (ir_a !== 1'b1) $display("FAIL mid_skid_ready got %0h exp 1", ir_a); else pass_cnt++;
      tick();
      in_valid = 1'b0;
      #1;
      total_cnt++; if (ov_a !== 1'b1 || od_a !== 32'hA5A5_0001) $display("FAIL mid_full got %0h/%h exp 1/a5a50001", ov_a, od_a); else pass_cnt++;
      total_cnt++; if (ir_a !== 1'b0) $display("FAIL mid_skidded_ready got %0h exp 0", ir_a); else pass_cnt++;
      total_cnt++; if (sc_a !== 16'd4) $display("FAIL mid_stall got %0d exp 4", sc_a); else pass_cnt++;
      reset = 1'b1;
      #1;
      total_cnt++; if (ov_a !== 1'b0) $display("FAIL mid_rst_valid got %0h exp 0", ov_a); else pass_cnt++;
      total_cnt++; if (od_a !== 32'h0) $display("FAIL mid_rst_data got %h exp 0", od_a); else pass_cnt++;
      total_cnt++; if (sc_a !== 16'h0) $display("FAIL mid_rst_stall got %0d exp 0", sc_a); else pass_cnt++;
      total_cnt++; if (ir_a !== 1'b0) $display("FAIL mid_rst_ready got %0h exp 0", ir_a); else pass_cnt++;
      tick();
      reset = 1'b0;
      #1;
      total_cnt++; if (ir_a !== 1'b1) $display("FAIL mid_rel_ready got %0h exp 1", ir_a); else pass_cnt++;
      in_valid = 1'b1; in_data = 32'h3; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      #1;
      total_cnt++; if (ov_a !== 1'b1 || od_a !== 32'h3) $display("FAIL mid_after got %0h/%h exp 1/3", ov_a, od_a); else pass_cnt++;
      tick();
      total_cnt++; if (ov_a !== 1'b0) $display("FAIL mid_after_drain got %0h exp 0", ov_a); else pass_cnt++;
   endtask

   task automatic test_flush();
      in_valid = 1'b1; in_data = 32'h31; out_ready = 1'b0;
      tick();
      in_data = 32'h32;
      tick();
      flush = 1'b1; in_data = 32'h77;
      #1;
      total_cnt++; if (ir_a !== 1'b0) $display("FAIL flush_ready got %0h exp 0", ir_a); else pass_cnt++;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      total_cnt++; if (ov_a !== 1'b0) $display("FAIL flush_valid got %0h exp 0", ov_a); else pass_cnt++;
      total_cnt++; if (od_a !== 32'h0) $display("FAIL flush_data got %h exp 0", od_a); else pass_cnt++;
      total_cnt++; if (ir_a !== 1'b1) $display("FAIL flush_ready_after got %0h exp 1", ir_a); else pass_cnt++;
      total_cnt++; if (sc_a !== 16'd1) $display("FAIL flush_keeps_stall got %0d exp 1", sc_a); else pass_cnt++;
      tick();
      total_cnt++; if (ov_a !== 1'b0) $display("FAIL flush_no_ghost got %0h exp 0", ov_a); else pass_cnt++;
      // flush together with clr_stats
      in_valid = 1'b1; in_data = 32'h41;
      tick();
      in_valid = 1'b0;
      tick();
      total_cnt++; if (ov_a !== 1'b1 || sc_a !== 16'd2) $display("FAIL fc_pre got %0h/%0d exp 1/2", ov_a, sc_a); else pass_cnt++;
      flush = 1'b1; clr_stats = 1'b1;
      tick();
      flush = 1'b0; clr_stats = 1'b0;
      #1;
      total_cnt++; if (ov_a !== 1'b0 || sc_a !== 16'd0) $display("FAIL fc_post got %0h/%0d exp 0/0", ov_a, sc_a); else pass_cnt++;
   endtask

   task automatic test_saturation();
      do_reset();
      in_valid = 1'b1; in_data = 32'h9; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      repeat (6) tick();
      total_cnt++; if (sc_c !== 3'd6) $display("FAIL sat_count6 got %0d exp 6", sc_c); else pass_cnt++;
      repeat (4) tick();
      total_cnt++; if (sc_c !== 3'd7) $display("FAIL sat_count7 got %0d exp 7", sc_c); else pass_cnt++;
      total_cnt++; if (ov_c !== 1'b1 || od_c !== 32'h9) $display("FAIL sat_hold got %0h/%h exp 1/9", ov_c, od_c); else pass_cnt++;
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      #1;
      total_cnt++; if (sc_c !== 3'd0) $display("FAIL sat_clear got %0d exp 0", sc_c); else pass_cnt++;
      tick();
      total_cnt++; if (sc_c !== 3'd1) $display("FAIL sat_resume got %0d exp 1", sc_c); else pass_cnt++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_skid0();
      do_reset();
      in_valid = 1'b1; in_data = 32'h4; out_ready = 1'b1;
      #1;
      total_cnt++; if (ir_z !== 1'b1) $display("FAIL s0_empty_ready got %0h exp 1", ir_z); else pass_cnt++;
      tick();
      in_data = 32'h5; out_ready = 1'b0;
      #1;
      total_cnt++; if (ir_z !== 1'b0) $display("FAIL s0_full_blocked got %0h exp 0", ir_z); else pass_cnt++;
      out_ready = 1'b1;
      #1;
      total_cnt++; if (ir_z !== 1'b1) $display("FAIL s0_comb_ready got %0h exp 1", ir_z); else pass_cnt++;
      total_cnt++; if (ov_z !== 1'b1 || od_z !== 32'h4) $display("FAIL s0_out4 got %0h/%h exp 1/4", ov_z, od_z); else pass_cnt++;
      tick();
      in_valid = 1'b0;
      #1;
      total_cnt++; if (ov_z !== 1'b1 || od_z !== 32'h5) $display("FAIL s0_out5 got %0h/%h exp 1/5", ov_z, od_z); else pass_cnt++;
      tick();
      total_cnt++; if (ov_z !== 1'b0) $display("FAIL s0_drain got %0h exp 0", ov_z); else pass_cnt++;
      total_cnt++; if (sc_z !== 16'd0) $display("FAIL s0_stall got %0d exp 0", sc_z); else pass_cnt++;
      total_cnt++; if (ir_c !== 1'b1) $display("FAIL s0_ready_c got %0h exp 1", ir_c); else pass_cnt++;
   endtask

   initial begin
      clk = 1'b0; reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
      out_ready = 1'b0; clr_stats = 1'b0;
      pass_cnt = 0; total_cnt = 0;
      test_reset();
      test_stream();
      test_backpressure();
      test_reset_midstream();
      test_flush();
      test_saturation();
      test_skid0();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
